// File: rtl/enm_wave_ctrl_pkg.sv
// Shared types and constants for the enemy wave controller and its arbiter.
package enm_pkg;

  localparam int unsigned HP_W    = 7;
  localparam int unsigned NUM_ENM = 4;

  // Defaults tied to the enemy motion phase thresholds below:
  // spawn HP must sit above PH1_THR so motion starts in phase 1.
  localparam int unsigned HP_INIT_DEF = 100;
  localparam int unsigned DMG_DEF     = 10;
  localparam int unsigned PH1_THR     = 80;
  localparam int unsigned PH2_THR     = 40;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_FIGHT = 3'd2,
    ST_CLEAR = 3'd3,
    ST_WIN   = 3'd4
  } enm_state_e;

  typedef logic [HP_W-1:0] hp_t;

  // Saturating HP decrement: never wraps below zero.
  function automatic hp_t hp_sat_sub(input hp_t hp, input hp_t dmg);
    return (hp <= dmg) ? '0 : hp_t'(hp - dmg);
  endfunction

endpackage

// File: rtl/enm_wave_ctrl_if.sv
// Game-side bus of the wave controller: start/hit in, HP/grant/status out.
interface enm_wave_ctrl_if;
  logic       start;
  logic [3:0] hit;
  logic [6:0] enmhp1;
  logic [6:0] enmhp2;
  logic [6:0] enmhp3;
  logic [6:0] enmhp4;
  logic [3:0] grant;
  logic [1:0] wave;
  logic       fighting;
  logic       wave_clear;
  logic       win;

  modport master (
    output start, hit,
    input  enmhp1, enmhp2, enmhp3, enmhp4, grant, wave, fighting, wave_clear, win
  );

  modport slave (
    input  start, hit,
    output enmhp1, enmhp2, enmhp3, enmhp4, grant, wave, fighting, wave_clear, win
  );
endinterface

// File: rtl/enm_wave_ctrl_rr_arb.sv
// 4-way round-robin arbiter; search starts at the index after the last grant.
module enm_rr_arb
  import enm_pkg::*;
(
  input  logic               clk22,
  input  logic               rst,
  input  logic [NUM_ENM-1:0] req,
  input  logic               adv,
  output logic [NUM_ENM-1:0] gnt
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] idx;
  logic [1:0] win_idx;
  logic       found;

  // Pick the first requester at or after the pointer; move pointer past it.
  always_comb begin
    gnt     = '0;
    found   = 1'b0;
    idx     = '0;
    win_idx = '0;
    for (int unsigned k = 0; k < NUM_ENM; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        found   = 1'b1;
        win_idx = idx;
      end
    end
    if (found) begin
      gnt[win_idx] = 1'b1;
    end
    ptr_d = ptr_q;
    if (adv && found) begin
      ptr_d = win_idx + 2'd1;
    end
  end

  // Pointer register.
  always_ff @(posedge clk22) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/enm_wave_ctrl.sv
// Wave sequencer and hit-damage arbiter for the four enemies.
module enm_wave_ctrl
  import enm_pkg::*;
#(
  parameter int unsigned HP_INIT     = HP_INIT_DEF,
  parameter int unsigned DMG         = DMG_DEF,
  parameter int unsigned NUM_WAVES   = 3,
  parameter int unsigned CLEAR_DELAY = 64
) (
  input  logic            clk22,
  input  logic            rst,
  enm_wave_ctrl_if.slave  bus
);

  localparam int unsigned CNT_W    = (CLEAR_DELAY > 1) ? $clog2(CLEAR_DELAY) : 1;
  localparam hp_t         HP_INIT_V = hp_t'(HP_INIT);
  localparam hp_t         DMG_V     = hp_t'(DMG);

  enm_state_e                   state_q, state_d;
  logic [NUM_ENM-1:0][HP_W-1:0] hp_q, hp_d;
  logic [NUM_ENM-1:0]           pending_q, pending_d;
  logic [NUM_ENM-1:0]           grant_q, grant_d;
  logic [1:0]                   wave_q, wave_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [NUM_ENM-1:0]           hp_nz;
  logic [NUM_ENM-1:0]           arb_req;
  logic [NUM_ENM-1:0]           gnt;
  logic                         in_fight;

  // Alive mask and arbiter request; only live, pending enemies compete in FIGHT.
  always_comb begin
    for (int unsigned i = 0; i < NUM_ENM; i++) begin
      hp_nz[i] = (hp_q[i] != '0);
    end
    in_fight = (state_q == ST_FIGHT);
    arb_req  = in_fight ? (pending_q & hp_nz) : '0;
  end

  enm_rr_arb u_arb (
    .clk22 (clk22),
    .rst   (rst),
    .req   (arb_req),
    .adv   (in_fight),
    .gnt   (gnt)
  );

  // Next-state, HP datapath, pending vector and clear-delay counter.
  always_comb begin
    state_d   = state_q;
    hp_d      = hp_q;
    pending_d = '0;
    grant_d   = '0;
    wave_d    = wave_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        hp_d = '0;
        if (bus.start) begin
          state_d = ST_SPAWN;
          wave_d  = '0;
        end
      end
      ST_SPAWN: begin
        for (int unsigned i = 0; i < NUM_ENM; i++) begin
          hp_d[i] = HP_INIT_V;
        end
        state_d = ST_FIGHT;
      end
      ST_FIGHT: begin
        grant_d = gnt;
        // New hits are masked by post-grant HP so a killing hit never
        // leaves a stale pending bit that would block the wave clear.
        for (int unsigned i = 0; i < NUM_ENM; i++) begin
          if (gnt[i]) begin
            hp_d[i] = hp_sat_sub(hp_q[i], DMG_V);
          end
          pending_d[i] = ((pending_q[i] & ~gnt[i]) | bus.hit[i]) & (hp_d[i] != '0);
        end
        if (hp_nz == '0 && pending_q == '0) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        if (cnt_q == CNT_W'(CLEAR_DELAY - 1)) begin
          if (wave_q == 2'(NUM_WAVES - 1)) begin
            state_d = ST_WIN;
          end else begin
            wave_d  = wave_q + 2'd1;
            state_d = ST_SPAWN;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WIN: begin
        hp_d = '0;
        if (bus.start) begin
          state_d = ST_SPAWN;
          wave_d  = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        hp_d    = '0;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk22) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      hp_q      <= '0;
      pending_q <= '0;
      grant_q   <= '0;
      wave_q    <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hp_q      <= hp_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      wave_q    <= wave_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.enmhp1     = hp_q[0];
  assign bus.enmhp2     = hp_q[1];
  assign bus.enmhp3     = hp_q[2];
  assign bus.enmhp4     = hp_q[3];
  assign bus.grant      = grant_q;
  assign bus.wave       = wave_q;
  assign bus.fighting   = (state_q == ST_FIGHT);
  assign bus.wave_clear = (state_q == ST_CLEAR);
  assign bus.win        = (state_q == ST_WIN);

endmodule

// File: tb/tb_enm_wave_ctrl.sv
// Scoreboard bench for enm_wave_ctrl (HP_INIT=95, DMG=10, 3 waves, CLEAR_DELAY=4).
module tb_enm_wave_ctrl;

  localparam logic [2:0] F_IDLE  = 3'b000;
  localparam logic [2:0] F_FIGHT = 3'b100;
  localparam logic [2:0] F_CLEAR = 3'b010;
  localparam logic [2:0] F_WIN   = 3'b001;

  typedef struct {
    int          cyc;
    string       name;
    logic [36:0] val;
  } exp_t;

  logic clk22;
  logic rst;
  int   cyc;
  int   n_vec;
  int   n_err;
  exp_t sb_q[$];

  enm_wave_ctrl_if bus ();

  enm_wave_ctrl #(
    .HP_INIT     (95),
    .DMG         (10),
    .NUM_WAVES   (3),
    .CLEAR_DELAY (4)
  ) dut (
    .clk22 (clk22),
    .rst   (rst),
    .bus   (bus)
  );

  initial clk22 = 1'b0;
  always #5 clk22 = ~clk22;

  always @(posedge clk22) cyc <= cyc + 1;

  // One clock: drive inputs on the falling edge, return just after the rising edge.
  task automatic tick(input logic r, input logic s, input logic [3:0] h);
    @(negedge clk22);
    rst       = r;
    bus.start = s;
    bus.hit   = h;
    @(posedge clk22);
    #1;
  endtask

  // Expected outputs after the edge just taken.
  task automatic chk(input string nm, input logic [6:0] h1, input logic [6:0] h2,
                     input logic [6:0] h3, input logic [6:0] h4, input logic [3:0] g,
                     input logic [1:0] w, input logic [2:0] f);
    exp_t e;
    e.cyc  = cyc;
    e.name = nm;
    e.val  = {h1, h2, h3, h4, g, w, f};
    sb_q.push_back(e);
  endtask

  // Monitor: compares every queued expectation due this cycle.
  initial begin
    exp_t        e;
    logic [36:0] act;
    forever begin
      @(negedge clk22);
      while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
        e   = sb_q.pop_front();
        act = {bus.enmhp1, bus.enmhp2, bus.enmhp3, bus.enmhp4, bus.grant, bus.wave,
               bus.fighting, bus.wave_clear, bus.win};
        n_vec++;
        if (e.cyc != cyc || act !== e.val) begin
          n_err++;
          $display("FAIL %s cyc=%0d(due %0d) got hp=%0d,%0d,%0d,%0d g=%b w=%0d f/c/w=%b want hp=%0d,%0d,%0d,%0d g=%b w=%0d f/c/w=%b",
                   e.name, cyc, e.cyc, act[36:30], act[29:23], act[22:16], act[15:9],
                   act[8:5], act[4:3], act[2:0], e.val[36:30], e.val[29:23],
                   e.val[22:16], e.val[15:9], e.val[8:5], e.val[4:3], e.val[2:0]);
        end
      end
    end
  end

  // Kill all four enemies with continuous hits from a fresh wave (pointer at 0).
  task automatic kill_wave(input logic [1:0] w, input bit last);
    tick(0, 0, 4'hF);
    for (int t = 2; t <= 40; t++) tick(0, 0, 4'hF);
    chk("kill_last", 0, 0, 0, 5, 4'b0100, w, F_FIGHT);
    tick(0, 0, 4'hF);
    chk("kill_done", 0, 0, 0, 0, 4'b1000, w, F_FIGHT);
    tick(0, 0, 4'hF);
    chk("clr_enter", 0, 0, 0, 0, 4'b0000, w, F_CLEAR);
    tick(0, 0, 4'hF);
    tick(0, 0, 4'hF);
    tick(0, 0, 4'hF);
    chk("clr_4th", 0, 0, 0, 0, 4'b0000, w, F_CLEAR);
    tick(0, 0, 4'h0);
    if (last) begin
      chk("win", 0, 0, 0, 0, 4'b0000, w, F_WIN);
      tick(0, 0, 4'hF);
      chk("win_hold", 0, 0, 0, 0, 4'b0000, w, F_WIN);
    end else begin
      chk("next_spawn", 0, 0, 0, 0, 4'b0000, w + 2'd1, F_IDLE);
      tick(0, 0, 4'h0);
      chk("next_fight", 95, 95, 95, 95, 4'b0000, w + 2'd1, F_FIGHT);
    end
  endtask

  initial begin
    cyc       = 0;
    n_vec     = 0;
    n_err     = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.hit   = '0;

    tick(1, 0, 4'h0);
    chk("reset", 0, 0, 0, 0, 4'b0000, 0, F_IDLE);
    tick(0, 0, 4'hF);
    chk("idle_hit_drop", 0, 0, 0, 0, 4'b0000, 0, F_IDLE);
    tick(0, 1, 4'h0);
    chk("spawn", 0, 0, 0, 0, 4'b0000, 0, F_IDLE);
    tick(0, 0, 4'h0);
    chk("fight_init", 95, 95, 95, 95, 4'b0000, 0, F_FIGHT);

    // All four hit once: round-robin from enemy 1.
    tick(0, 0, 4'hF);
    chk("all_capture", 95, 95, 95, 95, 4'b0000, 0, F_FIGHT);
    tick(0, 0, 4'h0);
    chk("rr_g1", 85, 95, 95, 95, 4'b0001, 0, F_FIGHT);
    tick(0, 0, 4'h0);
    chk("rr_g2", 85, 85, 95, 95, 4'b0010, 0, F_FIGHT);
    tick(0, 0, 4'h0);
    chk("rr_g3", 85, 85, 85, 95, 4'b0100, 0, F_FIGHT);
    tick(0, 0, 4'h0);
    chk("rr_g4", 85, 85, 85, 85, 4'b1000, 0, F_FIGHT);
    tick(0, 0, 4'h0);
    chk("rr_idle", 85, 85, 85, 85, 4'b0000, 0, F_FIGHT);

    // Second round starts at enemy 1 again (pointer wrapped).
    tick(0, 0, 4'hF);
    tick(0, 0, 4'h0);
    chk("rr2_g1", 75, 85, 85, 85, 4'b0001, 0, F_FIGHT);
    tick(0, 0, 4'h0);
    tick(0, 0, 4'h0);
    tick(0, 0, 4'h0);
    chk("rr2_g4", 75, 75, 75, 75, 4'b1000, 0, F_FIGHT);

    // Single hit on enemy 2.
    tick(0, 0, 4'b0010);
    chk("e2_capture", 75, 75, 75, 75, 4'b0000, 0, F_FIGHT);
    tick(0, 0, 4'h0);
    chk("e2_grant", 75, 65, 75, 75, 4'b0010, 0, F_FIGHT);

    // Continuous hits on enemy 3 down through saturation.
    tick(0, 0, 4'b0100);
    tick(0, 0, 4'b0100);
    chk("e3_first", 75, 65, 65, 75, 4'b0100, 0, F_FIGHT);
    for (int t = 2; t <= 7; t++) tick(0, 0, 4'b0100);
    chk("e3_hp5", 75, 65, 5, 75, 4'b0100, 0, F_FIGHT);
    tick(0, 0, 4'b0100);
    chk("e3_sat0", 75, 65, 0, 75, 4'b0100, 0, F_FIGHT);
    tick(0, 0, 4'b0100);
    chk("e3_dead_nogrant", 75, 65, 0, 75, 4'b0000, 0, F_FIGHT);
    tick(0, 0, 4'b0100);
    chk("e3_dead_nopend", 75, 65, 0, 75, 4'b0000, 0, F_FIGHT);

    // Enemies 1, 2, 4 hit continuously; pointer sits after enemy 3.
    tick(0, 0, 4'b1011);
    chk("mix_capture", 75, 65, 0, 75, 4'b0000, 0, F_FIGHT);
    tick(0, 0, 4'b1011);
    chk("mix_g4", 75, 65, 0, 65, 4'b1000, 0, F_FIGHT);
    tick(0, 0, 4'b1011);
    chk("mix_g1", 65, 65, 0, 65, 4'b0001, 0, F_FIGHT);
    tick(0, 0, 4'b1011);
    chk("mix_g2", 65, 55, 0, 65, 4'b0010, 0, F_FIGHT);
    for (int t = 4; t <= 21; t++) tick(0, 0, 4'b1011);
    chk("mix_r7", 5, 0, 0, 5, 4'b0010, 0, F_FIGHT);
    tick(0, 0, 4'b1011);
    chk("mix_e4_dead", 5, 0, 0, 0, 4'b1000, 0, F_FIGHT);
    tick(0, 0, 4'b1011);
    chk("mix_all_dead", 0, 0, 0, 0, 4'b0001, 0, F_FIGHT);

    // CLEAR lasts 4 cycles, hits ignored, then wave 1 spawns.
    tick(0, 0, 4'hF);
    chk("clr_c1", 0, 0, 0, 0, 4'b0000, 0, F_CLEAR);
    tick(0, 0, 4'hF);
    chk("clr_c2", 0, 0, 0, 0, 4'b0000, 0, F_CLEAR);
    tick(0, 0, 4'hF);
    chk("clr_c3", 0, 0, 0, 0, 4'b0000, 0, F_CLEAR);
    tick(0, 0, 4'hF);
    chk("clr_c4", 0, 0, 0, 0, 4'b0000, 0, F_CLEAR);
    tick(0, 0, 4'hF);
    chk("w1_spawn", 0, 0, 0, 0, 4'b0000, 1, F_IDLE);
    tick(0, 0, 4'h0);
    chk("w1_fight", 95, 95, 95, 95, 4'b0000, 1, F_FIGHT);

    // Reset with pending=1011 in FIGHT.
    tick(0, 0, 4'b1011);
    chk("pre_rst", 95, 95, 95, 95, 4'b0000, 1, F_FIGHT);
    tick(1, 0, 4'h0);
    chk("mid_rst", 0, 0, 0, 0, 4'b0000, 0, F_IDLE);
    tick(0, 1, 4'h0);
    chk("rst_spawn", 0, 0, 0, 0, 4'b0000, 0, F_IDLE);
    tick(0, 0, 4'h0);
    chk("rst_fight", 95, 95, 95, 95, 4'b0000, 0, F_FIGHT);
    tick(0, 0, 4'h0);
    chk("no_stale", 95, 95, 95, 95, 4'b0000, 0, F_FIGHT);

    // Three full waves to WIN, then restart.
    kill_wave(2'd0, 1'b0);
    kill_wave(2'd1, 1'b0);
    kill_wave(2'd2, 1'b1);
    tick(0, 1, 4'h0);
    chk("restart_spawn", 0, 0, 0, 0, 4'b0000, 0, F_IDLE);
    tick(0, 0, 4'h0);
    chk("restart_fight", 95, 95, 95, 95, 4'b0000, 0, F_FIGHT);

    repeat (3) @(posedge clk22);
    #1;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Run-time bound.
  initial begin
    #100000;
    n_err++;
    $display("FAIL watchdog: run did not complete, %0d expectations pending", sb_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
